// File: rtl/pdm_pkg.sv
// Shared constants, state type and saturation helper for the PCM-to-PDM transmitter.
package pdm_pkg;

  localparam int PDM_FB_POS = 32768;
  localparam int PDM_FB_NEG = -32768;
  localparam int PDM_I1_W   = 18;
  localparam int PDM_I2_W   = 22;
  localparam int PCM_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVED
  } pdm_state_t;

  // Clamp a 32-bit signed value into the range of a w-bit signed integer.
  function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Single-clock PCM sample FIFO with show-ahead head data and full/empty flags.
module pcm_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign do_rd   = rd_en && !empty;
  // A full buffer still takes a write in the same cycle its head is popped.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pcm2pdm_tx.sv
// PCM-to-PDM transmitter: sample FIFO, bit/sample tick counters and a saturating
// sigma-delta modulator; define PCM2PDM_TX_SECOND_ORDER_EN for the second-order loop.
module pcm2pdm_tx
  import pdm_pkg::*;
#(
  parameter int DIVCOUNT   = 25,
  parameter int OSR        = 125,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [PCM_W-1:0] dat_i,
  input  logic                    dv_i,
  output logic                    ready_o,
  output logic                    sclk_o,
  output logic                    pdm_o,
  output logic                    underrun_o
);

  localparam int CW = (DIVCOUNT > 1) ? $clog2(DIVCOUNT) : 1;
  localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [CW-1:0]              cnt_reg;
  logic [SW-1:0]              scnt_reg;
  logic                       sclk_reg;
  logic                       pdm_reg;
  logic                       pdm_next;
  logic                       underrun_reg;
  logic                       underrun_next;
  logic                       tick;
  logic                       wrap;
  pdm_state_t                 state_reg;
  pdm_state_t                 state_next;
  logic signed [PCM_W-1:0]    x_reg;
  logic signed [PCM_W-1:0]    x_next;
  logic signed [PDM_I1_W-1:0] i1_reg;
  logic signed [PDM_I1_W-1:0] i1_next;
  logic signed [31:0]         fb;
  logic signed [31:0]         i1_sum;
  logic                       fifo_rd;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [PCM_W-1:0]           fifo_head;
`ifdef PCM2PDM_TX_SECOND_ORDER_EN
  logic signed [PDM_I2_W-1:0] i2_reg;
  logic signed [PDM_I2_W-1:0] i2_next;
  logic signed [31:0]         i2_sum;
`endif

  pcm_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset),
    .wr_en   (dv_i),
    .wr_data (dat_i),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready_o    = !fifo_full;
  assign sclk_o     = sclk_reg;
  assign pdm_o      = pdm_reg;
  assign underrun_o = underrun_reg;
  assign tick       = (cnt_reg == '0);
  assign wrap       = tick && (scnt_reg == SW'(OSR - 1));

  // sclk is registered from the count, so its rising edge lands on the same
  // clock edge that updates pdm.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      scnt_reg <= '0;
      sclk_reg <= 1'b0;
    end else begin
      cnt_reg  <= (cnt_reg == CW'(DIVCOUNT - 1)) ? '0 : cnt_reg + CW'(1);
      sclk_reg <= (cnt_reg < CW'(DIVCOUNT / 2));
      if (tick) scnt_reg <= wrap ? '0 : scnt_reg + SW'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    fifo_rd       = 1'b0;
    underrun_next = 1'b0;
    if (wrap) begin
      if (!fifo_empty) begin
        fifo_rd    = 1'b1;
        x_next     = signed'(fifo_head);
        state_next = RUN;
      end else begin
        x_next = '0;
        if (state_reg == RUN) begin
          state_next    = STARVED;
          underrun_next = 1'b1;
        end
      end
    end
  end

  // The freshly loaded sample already drives the loop on its wrap tick.
  always_comb begin
    fb      = pdm_reg ? PDM_FB_POS : PDM_FB_NEG;
    i1_sum  = 32'(i1_reg) + 32'(x_next) - fb;
    i1_next = PDM_I1_W'(sat_to(i1_sum, PDM_I1_W));
`ifdef PCM2PDM_TX_SECOND_ORDER_EN
    i2_sum   = 32'(i2_reg) + 32'(i1_next) - fb;
    i2_next  = PDM_I2_W'(sat_to(i2_sum, PDM_I2_W));
    pdm_next = !i2_next[PDM_I2_W-1];
`else
    pdm_next = !i1_next[PDM_I1_W-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      i1_reg       <= '0;
      pdm_reg      <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= underrun_next;
      if (tick) begin
        state_reg <= state_next;
        x_reg     <= x_next;
        i1_reg    <= i1_next;
        pdm_reg   <= pdm_next;
      end
    end
  end

`ifdef PCM2PDM_TX_SECOND_ORDER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      i2_reg <= '0;
    end else if (tick) begin
      i2_reg <= i2_next;
    end
  end
`endif

endmodule

// File: tb/tb_pcm2pdm_tx.sv
// Directed bench for pcm2pdm_tx using a short bit period (DIVCOUNT=4) and OSR=16.
module tb_pcm2pdm_tx;
  import pdm_pkg::*;

  localparam int DIV   = 4;
  localparam int OSR   = 16;
  localparam int DEPTH = 4;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              dv_i     = 1'b0;
  logic signed [15:0] dat_i   = '0;
  logic              ready_o;
  logic              sclk_o;
  logic              pdm_o;
  logic              underrun_o;

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          ur_cnt   = 0;
  logic        feed_en  = 1'b0;
  logic [15:0] feed_dat = '0;
  logic [15:0] samp   [5];
  logic [15:0] exp_rd [4];

  always #5 clk = ~clk;

  pcm2pdm_tx #(
    .DIVCOUNT   (DIV),
    .OSR        (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dat_i      (dat_i),
    .dv_i       (dv_i),
    .ready_o    (ready_o),
    .sclk_o     (sclk_o),
    .pdm_o      (pdm_o),
    .underrun_o (underrun_o)
  );

  // Counts every clock cycle the underrun flag is high.
  always @(negedge clk) if (underrun_o) ur_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to the negedge after the next sclk rise, feeding the FIFO if enabled.
  task automatic next_tick();
    logic prev;
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 4 * DIV; k++) begin
      prev = sclk_o;
      @(negedge clk);
      dv_i  = feed_en && ready_o;
      dat_i = feed_dat;
      if (!prev && sclk_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("tick_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_wrap();
    for (int k = 0; k < OSR + 2; k++) begin
      next_tick();
      if (dut.scnt_reg == '0) return;
    end
    chk("wrap_timeout", 32'(dut.scnt_reg), 32'd0);
  endtask

  task automatic seek(input int scnt_val, input bit at_tick);
    for (int k = 0; k < 2 * DIV * OSR; k++) begin
      if (int'(dut.scnt_reg) == scnt_val && (!at_tick || dut.cnt_reg == '0)) return;
      @(negedge clk);
    end
    chk("seek_timeout", 32'(dut.scnt_reg), 32'(scnt_val));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ur0;
    int          ones;
    int          changes;
    logic [31:0] pat;
    logic        prev_pdm;

    samp   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    exp_rd = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pdm", 32'(pdm_o), 32'd0);
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_underrun", 32'(underrun_o), 32'd0);
    reset = 1'b0;

    // No writes: idle mid-scale pattern 1,1,0,1,0,1,... and no underrun
    ur0 = ur_cnt;
    pat = '0;
    for (int t = 0; t < 2 * OSR; t++) begin
      next_tick();
      pat = {pat[30:0], pdm_o};
    end
`ifndef PCM2PDM_TX_SECOND_ORDER_EN
    chk("idle_pattern", pat, 32'hD555_5555);
`endif
    chk("idle_no_underrun", 32'(ur_cnt - ur0), 32'd0);
    chk("idle_state", 32'(dut.state_reg), 32'(IDLE));

    // Five back-to-back writes into a 4-deep FIFO
    for (int k = 0; k < 5; k++) begin
      dv_i  = 1'b1;
      dat_i = samp[k];
      @(negedge clk);
      chk($sformatf("fifo_ready_after_wr%0d", k + 1), 32'(ready_o), (k >= 3) ? 32'd0 : 32'd1);
    end
    dv_i = 1'b0;

    // Write while full on the wrap cycle: pop and push both happen
    seek(OSR - 1, 1'b1);
    dv_i  = 1'b1;
    dat_i = 16'h6666;
    @(negedge clk);
    dv_i = 1'b0;
    chk("full_wr_rd_ready", 32'(ready_o), 32'd0);
    chk("first_read", {16'd0, dut.x_reg}, 32'h1111);
    chk("first_read_state", 32'(dut.state_reg), 32'(RUN));
    for (int k = 0; k < 4; k++) begin
      wait_wrap();
      chk($sformatf("read%0d", k + 2), {16'd0, dut.x_reg}, {16'd0, exp_rd[k]});
    end
    ur0 = ur_cnt;
    wait_wrap();
    @(negedge clk);
    chk("drain_underrun", 32'(ur_cnt - ur0), 32'd1);
    chk("drain_state", 32'(dut.state_reg), 32'(STARVED));
    chk("drain_x", {16'd0, dut.x_reg}, 32'd0);

    // Single 0x7FFF sample, then starvation
    dv_i  = 1'b1;
    dat_i = 16'h7FFF;
    @(negedge clk);
    dv_i = 1'b0;
    ur0  = ur_cnt;
    wait_wrap();
    chk("single_x", {16'd0, dut.x_reg}, 32'h7FFF);
    chk("single_state", 32'(dut.state_reg), 32'(RUN));
    wait_wrap();
    @(negedge clk);
    chk("single_underrun", 32'(ur_cnt - ur0), 32'd1);
    chk("single_starved", 32'(dut.state_reg), 32'(STARVED));
    changes  = 0;
    prev_pdm = pdm_o;
    for (int t = 0; t < 16; t++) begin
      next_tick();
      if (t >= 5 && pdm_o != prev_pdm) changes++;
      prev_pdm = pdm_o;
    end
`ifndef PCM2PDM_TX_SECOND_ORDER_EN
    chk("resume_alternating", 32'(changes), 32'd11);
`endif

    // Steady 0x4000: ones density 0.75
    feed_dat = 16'h4000;
    feed_en  = 1'b1;
    wait_wrap();
    wait_wrap();
    chk("dens_x", {16'd0, dut.x_reg}, 32'h4000);
    ones = 0;
    for (int t = 0; t < 1000; t++) begin
      next_tick();
      ones += int'(pdm_o);
    end
    chk("dens_ones", (ones >= 748 && ones <= 752) ? 32'd750 : 32'(ones), 32'd750);

    // Steady -32768: all zeros, integrator stays negative
    feed_dat = 16'h8000;
    for (int k = 0; k < 6; k++) wait_wrap();
    chk("neg_x", {16'd0, dut.x_reg}, 32'h8000);
    for (int t = 0; t < 100; t++) next_tick();
    ones = 0;
    for (int t = 0; t < 10000; t++) begin
      next_tick();
      ones += int'(pdm_o);
    end
    chk("neg_ones", 32'(ones), 32'd0);
    chk("neg_i1_sign", 32'(dut.i1_reg[PDM_I1_W-1]), 32'd1);

    // Reset mid-sample with three samples queued
    feed_en = 1'b0;
    dv_i    = 1'b0;
    wait_wrap();
    chk("pre_rst_state", 32'(dut.state_reg), 32'(RUN));
    chk("pre_rst_queued", 32'(dut.u_fifo.empty), 32'd0);
    seek(OSR / 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pdm", 32'(pdm_o), 32'd0);
    chk("mid_rst_sclk", 32'(sclk_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_underrun", 32'(underrun_o), 32'd0);
    chk("mid_rst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
    chk("mid_rst_state", 32'(dut.state_reg), 32'(IDLE));
    chk("mid_rst_scnt", 32'(dut.scnt_reg), 32'd0);
    reset = 1'b0;
    ur0   = ur_cnt;
    for (int t = 0; t < 2 * OSR + 2; t++) next_tick();
    chk("post_rst_no_underrun", 32'(ur_cnt - ur0), 32'd0);
    chk("post_rst_state", 32'(dut.state_reg), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
